ps2_keyboard_rx: RTL

//  PS/2 keyboard receiver feeding the melody/tone stage. Samples raw ps2_clk/ps2_data,

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_clk_filter.sv | 59 +++++
 rtl/ps2_keyboard_rx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and frame-state encoding for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] KEY_NONE  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises raw PS/2 clock/data, glitch-filters the clock and emits a
// one-cycle pulse on each accepted falling edge of the filtered clock.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall_q, fall_d;

    // The filtered level only moves after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        fall_d = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
                fall_d = filt_q;
            end else begin
                cnt_d = CW'(cnt_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            cnt_q    <= '0;
            fall_q   <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            fall_q   <= fall_d;
        end
    end

    assign data_sync = dat_s2_q;
    assign fall      = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame FSM, inter-edge watchdog and make/break key tracker.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic data_s, fall;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          brk_q, brk_d, ext_q, ext_d;
    logic [7:0]    key_q, key_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          parity_ok;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_sync (data_s),
        .fall      (fall)
    );

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign parity_ok = !PAR_EN || (^{shift_q, parity_q});

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        wdog_d       = '0;
        brk_d        = brk_q;
        ext_d        = ext_q;
        key_d        = key_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q != ST_IDLE) begin
            wdog_d = fall ? '0 : WW'(wdog_q + 1'b1);
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (fall && !data_s) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    parity_d = data_s;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (data_s && parity_ok) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                        if (shift_q == PS2_BREAK) begin
                            brk_d = 1'b1;
                        end else if (shift_q == PS2_EXT) begin
                            ext_d = 1'b1;
                        end else if (ext_q) begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end else if (brk_q) begin
                            brk_d = 1'b0;
                            if (shift_q == key_q) key_d = KEY_NONE;
                        end else begin
                            key_d = shift_q;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fall always resets the watchdog, so a timeout never coincides with a byte accept.
        if (state_q != ST_IDLE && !fall && wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            wdog_q       <= '0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            key_q        <= KEY_NONE;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            wdog_q       <= wdog_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            key_q        <= key_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign key_code   = key_q;
    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule
